// File: rtl/dmem_pkg.sv
// Shared data-memory definitions: address split, data width and miss FSM states.
package dmem_pkg;

  localparam int unsigned ADDR_LEN   = 25;
  localparam int unsigned TAG_LEN    = 9;
  localparam int unsigned INDEX_LEN  = 14;
  localparam int unsigned OFFSET_LEN = 2;
  localparam int unsigned DATA_LEN   = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } miss_state_t;

endpackage

// File: rtl/dmem_miss_resp_if.sv
// Cache-side request/response and memory-side request/response bundle for the miss responder.
interface dmem_miss_resp_if
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_LEN,
  parameter int unsigned DATA_W = DATA_LEN
) ();

  // cache front end
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_we;
  logic [DATA_W-1:0] req_wdata;
  logic              arrive;
  logic [DATA_W-1:0] data_arrived;
  logic              err;
  logic              busy;

  // backing memory
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;

  // responder side
  modport slave (
    input  req_valid, req_addr, req_we, req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output req_ready, arrive, data_arrived, err, busy,
    output mem_req_valid, mem_addr, mem_we, mem_wdata
  );

  // cache + memory environment side
  modport master (
    output req_valid, req_addr, req_we, req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  req_ready, arrive, data_arrived, err, busy,
    input  mem_req_valid, mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/dmem_miss_resp.sv
// Data-cache miss/write-through responder: one request in flight, forwarded to
// backing memory, completion reported as a one-cycle arrive (or err on timeout).
module dmem_miss_resp
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_LEN,
  parameter int unsigned DATA_W  = DATA_LEN,
  parameter int unsigned TIMEOUT = 1023
) (
  input logic            clk,
  input logic            rst,
  dmem_miss_resp_if.slave bus
);

  localparam int unsigned      CNT_W      = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(TIMEOUT);
  localparam bit               TIMEOUT_EN = (TIMEOUT != 0);

  miss_state_t       state;
  logic [CNT_W-1:0]  cnt;
  logic              mem_req_valid_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] data_q;
  logic              arrive_q;
  logic              err_q;
  logic              busy_q;

  // Request tracking FSM with registered outputs; timeout counter saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      mem_req_valid_q <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      data_q          <= '0;
      arrive_q        <= 1'b0;
      err_q           <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      arrive_q <= 1'b0;
      err_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            mem_addr_q      <= bus.req_addr;
            mem_we_q        <= bus.req_we;
            mem_wdata_q     <= bus.req_wdata;
            mem_req_valid_q <= 1'b1;
            busy_q          <= 1'b1;
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          // mem_req_valid is already high here, so ready alone completes the handshake
          if (bus.mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            cnt             <= '0;
            state           <= WAIT;
          end
        end
        WAIT: begin
          // a response in the limit cycle beats the timeout
          if (bus.mem_rsp_valid) begin
            data_q   <= bus.mem_rsp_data;
            arrive_q <= 1'b1;
            state    <= DONE;
          end else if (TIMEOUT_EN && (cnt == CNT_LIMIT)) begin
            err_q <= 1'b1;
            state <= DONE;
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Accept only when idle; everything else comes straight from registers.
  assign bus.req_ready     = (state == IDLE);
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.data_arrived  = data_q;
  assign bus.arrive        = arrive_q;
  assign bus.err           = err_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_dmem_miss_resp.sv
// Bench for dmem_miss_resp: directed scenarios with literal expectations, then
// random traffic, all checked every cycle against a transaction-level model.
module tb_dmem_miss_resp;
  import dmem_pkg::*;

  localparam int unsigned AW = ADDR_LEN;
  localparam int unsigned DW = DATA_LEN;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst;

  int vectors     = 0;
  int miscompares = 0;

  dmem_miss_resp_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_miss_resp #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a single outstanding transaction described by what has happened to it.
  bit            m_have;     // transaction accepted and not yet retired
  bit            m_handed;   // memory has taken the request
  int            m_waited;   // response-wait cycles already elapsed
  int            m_fin;      // 0 none, 1 completed, 2 timed out (reported this cycle)
  logic [AW-1:0] m_addr;
  logic          m_we;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_data;

  // Advance the model on each edge from the sampled inputs, then compare just after.
  always @(posedge clk) begin
    if (rst) begin
      m_have = 0; m_handed = 0; m_waited = 0; m_fin = 0;
      m_addr = '0; m_we = 1'b0; m_wdata = '0; m_data = '0;
    end else if (m_fin != 0) begin
      m_fin  = 0;
      m_have = 0;
    end else if (!m_have) begin
      if (bus.req_valid) begin
        m_have = 1; m_handed = 0;
        m_addr = bus.req_addr; m_we = bus.req_we; m_wdata = bus.req_wdata;
      end
    end else if (!m_handed) begin
      if (bus.mem_req_ready) begin
        m_handed = 1; m_waited = 0;
      end
    end else if (bus.mem_rsp_valid) begin
      m_data = bus.mem_rsp_data;
      m_fin  = 1;
    end else if (m_waited == int'(TO)) begin
      m_fin = 2;
    end else begin
      m_waited++;
    end
    #1;
    chk("req_ready",     32'(bus.req_ready),     32'(!m_have));
    chk("busy",          32'(bus.busy),          32'(m_have));
    chk("mem_req_valid", 32'(bus.mem_req_valid), 32'(m_have && !m_handed));
    chk("arrive",        32'(bus.arrive),        32'(m_fin == 1));
    chk("err",           32'(bus.err),           32'(m_fin == 2));
    chk("mem_addr",      32'(bus.mem_addr),      32'(m_addr));
    chk("mem_we",        32'(bus.mem_we),        32'(m_we));
    chk("mem_wdata",     32'(bus.mem_wdata),     32'(m_wdata));
    chk("data_arrived",  32'(bus.data_arrived),  32'(m_data));
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.req_valid     = 1'b0;
    bus.req_addr      = '0;
    bus.req_we        = 1'b0;
    bus.req_wdata     = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
  endtask

  task automatic send(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_we    = we;
    bus.req_wdata = wd;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    step(); step();
    chk("reset_req_ready",     32'(bus.req_ready),     32'd1);
    chk("reset_busy",          32'(bus.busy),          32'd0);
    chk("reset_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("reset_data_arrived",  32'(bus.data_arrived),  32'd0);
    rst = 1'b0;
    step();

    // read fill, response three cycles after handshake
    send(25'h0123456, 1'b0, 32'h1111_2222);
    bus.mem_req_ready = 1'b1;
    step();
    chk("rd_mem_req_valid", 32'(bus.mem_req_valid), 32'd1);
    chk("rd_mem_addr",      32'(bus.mem_addr),      32'h0123456);
    chk("rd_mem_we",        32'(bus.mem_we),        32'd0);
    bus.req_valid = 1'b0;
    step(); step(); step();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hDEADBEEF;
    step();
    bus.mem_rsp_valid = 1'b0;
    chk("rd_arrive", 32'(bus.arrive),  32'd1);
    chk("rd_data",   bus.data_arrived, 32'hDEADBEEF);
    chk("rd_err",    32'(bus.err),     32'd0);
    step();
    chk("rd_busy_low",    32'(bus.busy),   32'd0);
    chk("rd_arrive_once", 32'(bus.arrive), 32'd0);

    // write with four cycles of backpressure
    bus.mem_req_ready = 1'b0;
    send(25'h1FFFFFF, 1'b1, 32'hCAFEF00D);
    step();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("wr_hold_valid", 32'(bus.mem_req_valid), 32'd1);
      chk("wr_hold_addr",  32'(bus.mem_addr),      32'h1FFFFFF);
      chk("wr_hold_wdata", bus.mem_wdata,          32'hCAFEF00D);
      chk("wr_hold_we",    32'(bus.mem_we),        32'd1);
      step();
    end
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    chk("wr_valid_drop", 32'(bus.mem_req_valid), 32'd0);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h0000_0ACC;
    step();
    bus.mem_rsp_valid = 1'b0;
    chk("wr_arrive", 32'(bus.arrive), 32'd1);
    chk("wr_no_err", 32'(bus.err),    32'd0);
    step();

    // timeout: no response ever
    send(25'h0000ABC, 1'b0, 32'd0);
    bus.mem_req_ready = 1'b1;
    step();
    bus.req_valid = 1'b0;
    step();
    repeat (8) step();
    chk("to_err_not_early", 32'(bus.err), 32'd0);
    step();
    chk("to_err",       32'(bus.err),    32'd1);
    chk("to_no_arrive", 32'(bus.arrive), 32'd0);
    step();
    chk("to_err_once",  32'(bus.err),       32'd0);
    chk("to_ready",     32'(bus.req_ready), 32'd1);
    send(25'h0000DEF, 1'b0, 32'd0);
    step();
    chk("to_new_accept", 32'(bus.mem_req_valid), 32'd1);
    bus.req_valid = 1'b0;
    step();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h55;
    step();
    bus.mem_rsp_valid = 1'b0;
    chk("to_new_arrive", 32'(bus.arrive), 32'd1);
    step();

    // tie: response in the limit cycle
    send(25'h0000123, 1'b0, 32'd0);
    step();
    bus.req_valid = 1'b0;
    step();
    repeat (8) step();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h1;
    step();
    bus.mem_rsp_valid = 1'b0;
    chk("tie_arrive", 32'(bus.arrive),  32'd1);
    chk("tie_data",   bus.data_arrived, 32'h1);
    chk("tie_no_err", 32'(bus.err),     32'd0);
    step();

    // spurious response while idle
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hBAD0BAD0;
    step();
    bus.mem_rsp_valid = 1'b0;
    chk("sp_no_arrive", 32'(bus.arrive),  32'd0);
    chk("sp_busy",      32'(bus.busy),    32'd0);
    chk("sp_data_kept", bus.data_arrived, 32'h1);

    // back-to-back: second request held while the first is in flight
    send(25'h000AAAA, 1'b0, 32'd0);
    step();
    send(25'h1555555, 1'b1, 32'h7777_8888);
    step();
    chk("b2b_not_ready", 32'(bus.req_ready), 32'd0);
    chk("b2b_addr_a",    32'(bus.mem_addr),  32'h000AAAA);
    step();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h0A0A0A0A;
    step();
    bus.mem_rsp_valid = 1'b0;
    chk("b2b_arrive_a", 32'(bus.arrive),    32'd1);
    chk("b2b_done_nrd", 32'(bus.req_ready), 32'd0);
    step();
    chk("b2b_ready", 32'(bus.req_ready), 32'd1);
    step();
    chk("b2b_addr_b",  32'(bus.mem_addr),      32'h1555555);
    chk("b2b_valid_b", 32'(bus.mem_req_valid), 32'd1);
    bus.req_valid = 1'b0;
    step();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h0B0B0B0B;
    step();
    bus.mem_rsp_valid = 1'b0;
    chk("b2b_arrive_b", 32'(bus.arrive), 32'd1);
    step();

    // reset while waiting for the memory
    send(25'h0012345, 1'b1, 32'h1234_5678);
    step();
    bus.req_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rs_busy",      32'(bus.busy),          32'd0);
    chk("rs_valid",     32'(bus.mem_req_valid), 32'd0);
    chk("rs_addr",      32'(bus.mem_addr),      32'd0);
    chk("rs_we",        32'(bus.mem_we),        32'd0);
    chk("rs_wdata",     bus.mem_wdata,          32'd0);
    chk("rs_data",      bus.data_arrived,       32'd0);
    chk("rs_req_ready", 32'(bus.req_ready),     32'd1);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h77;
    step();
    bus.mem_rsp_valid = 1'b0;
    chk("rs_late_no_arrive", 32'(bus.arrive),  32'd0);
    chk("rs_late_no_data",   bus.data_arrived, 32'd0);
    bus.mem_req_ready = 1'b0;
    step();

    // random traffic, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      rst               = ($urandom_range(0, 99) == 0);
      bus.req_valid     = 1'($urandom);
      bus.req_addr      = AW'($urandom);
      bus.req_we        = 1'($urandom);
      bus.req_wdata     = $urandom;
      bus.mem_req_ready = ($urandom_range(0, 3) != 0);
      bus.mem_rsp_valid = ($urandom_range(0, 5) == 0);
      bus.mem_rsp_data  = $urandom;
      step();
    end
    rst = 1'b0;
    idle_inputs();
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
